// File: rtl/tpu_instr_buf_seq.sv
// Instruction buffer and sequencer between the TPU front-end and the scalar unit.
// Captures one program block, serves PC fetches while running, and returns its issue number on termination.
module tpu_instr_buf_seq #(
    parameter int INSTR_W = 64,
    parameter int DEPTH   = 64,
    parameter int ID_W    = 8,
    parameter int ISSUE_W = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               I_We,
    input  logic               I_Wr_End,
    input  logic [ID_W-1:0]    I_ThreadID,
    input  logic [ISSUE_W-1:0] I_IssueNo,
    input  logic [INSTR_W-1:0] I_Instr,
    output logic               O_Full,
    output logic               O_Nack,
    output logic               O_Ready,
    input  logic               I_Start,
    input  logic               I_Fetch,
    input  logic [AW-1:0]      I_PC,
    output logic               O_Valid,
    output logic [INSTR_W-1:0] O_Instr,
    output logic               O_Err,
    output logic [ID_W-1:0]    O_ThreadID,
    input  logic               I_Term,
    output logic               O_Done,
    output logic [ISSUE_W-1:0] O_IssueNo
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_P = (AW + 1)'(DEPTH);

    state_t               state_q, state_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          len_q, len_d;
    logic [ID_W-1:0]      thread_id_q, thread_id_d;
    logic [ISSUE_W-1:0]   issue_no_q, issue_no_d;
    logic                 full_q, full_d;
    logic                 nack_q, nack_d;
    logic                 ready_q, ready_d;
    logic                 valid_q, valid_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic [ISSUE_W-1:0]   o_issue_q, o_issue_d;
    logic                 full_cur_s;
    logic                 mem_we_s;
    logic [INSTR_W-1:0]   mem_q [DEPTH];

    // Full as seen by the front-end this cycle; matches the registered O_Full
    assign full_cur_s = ((state_q == LOAD) && (wr_ptr_q == DEPTH_P)) ||
                        (state_q == READY) || (state_q == RUN);

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            len_q       <= '0;
            thread_id_q <= '0;
            issue_no_q  <= '0;
            full_q      <= 1'b0;
            nack_q      <= 1'b0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            instr_q     <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            o_issue_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            len_q       <= len_d;
            thread_id_q <= thread_id_d;
            issue_no_q  <= issue_no_d;
            full_q      <= full_d;
            nack_q      <= nack_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
            done_q      <= done_d;
            o_issue_q   <= o_issue_d;
        end
    end

    // Instruction storage; deliberately not cleared, reads past len are masked instead
    always_ff @(posedge clock) begin
        if (mem_we_s && !reset) begin
            mem_q[wr_ptr_q[AW-1:0]] <= I_Instr;
        end
    end

    // Next-state and block bookkeeping; termination overrides everything else
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        len_d       = len_q;
        thread_id_d = thread_id_q;
        issue_no_d  = issue_no_q;
        mem_we_s    = 1'b0;
        if (I_Term) begin
            state_d     = IDLE;
            wr_ptr_d    = '0;
            len_d       = '0;
            thread_id_d = '0;
            issue_no_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (I_We) begin
                        mem_we_s    = 1'b1;
                        wr_ptr_d    = (AW + 1)'(1);
                        thread_id_d = I_ThreadID;
                        issue_no_d  = I_IssueNo;
                        if (I_Wr_End) begin
                            len_d   = (AW + 1)'(1);
                            state_d = READY;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD: begin
                    if (I_We) begin
                        if (!full_cur_s) begin
                            mem_we_s = 1'b1;
                            wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
                        end else begin
                            wr_ptr_d = wr_ptr_q;
                        end
                        // A dropped last write still closes the block, clamped at DEPTH
                        if (I_Wr_End) begin
                            len_d   = wr_ptr_d;
                            state_d = READY;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        state_d = LOAD;
                    end
                end
                READY: begin
                    if (I_Start) begin
                        state_d = RUN;
                    end else begin
                        state_d = READY;
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Registered output values, derived from the upcoming state where that state is reported
    always_comb begin
        full_d    = ((state_d == LOAD) && (wr_ptr_d == DEPTH_P)) ||
                    (state_d == READY) || (state_d == RUN);
        nack_d    = I_We && full_cur_s && !I_Term;
        ready_d   = (state_d == READY);
        valid_d   = (state_q == RUN) && I_Fetch && !I_Term;
        instr_d   = '0;
        err_d     = 1'b0;
        if (valid_d) begin
            if ({1'b0, I_PC} < len_q) begin
                instr_d = mem_q[I_PC];
                err_d   = 1'b0;
            end else begin
                instr_d = '0;
                err_d   = 1'b1;
            end
        end else begin
            instr_d = '0;
            err_d   = 1'b0;
        end
        done_d    = I_Term && (state_q == RUN);
        if (done_d) begin
            o_issue_d = issue_no_q;
        end else begin
            o_issue_d = '0;
        end
    end

    assign O_Full     = full_q;
    assign O_Nack     = nack_q;
    assign O_Ready    = ready_q;
    assign O_Valid    = valid_q;
    assign O_Instr    = instr_q;
    assign O_Err      = err_q;
    assign O_ThreadID = thread_id_q;
    assign O_Done     = done_q;
    assign O_IssueNo  = o_issue_q;

endmodule
